// File: rtl/seq_player.sv
// seq_player: replays a buffered colour pattern on the LED (and optionally audio) strobes with fixed on/off timing.
// Latency: start sampled at edge k gives the first ON strobe in cycle k+1; all outputs are registered.
// Backpressure: none; push/start arriving while busy are dropped, and a push into a full buffer sets sticky overflow.
//
// Ports: clock/reset (sync, active-high); push/push_color append to the buffer; clear empties it and aborts
// playback; start begins playback. Outputs: len, busy, done, overflow, led_strobe/led_color/led_on and
// snd_strobe/snd_color/snd_on.
// Build option: define SEQ_PLAYER_AUDIO_EN to drive the snd_* outputs; without it they are tied to 0.
module seq_player #(
    parameter int DEPTH      = 32,
    parameter int ON_CYCLES  = 25000000,
    parameter int OFF_CYCLES = 12500000
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [1:0]                 push_color,
    input  logic                       clear,
    input  logic                       start,
    output logic [$clog2(DEPTH+1)-1:0] len,
    output logic                       busy,
    output logic                       done,
    output logic                       overflow,
    output logic                       led_strobe,
    output logic [1:0]                 led_color,
    output logic                       led_on,
    output logic                       snd_strobe,
    output logic [2:0]                 snd_color,
    output logic                       snd_on
);

    localparam int LW   = $clog2(DEPTH + 1);
    localparam int IW   = $clog2(DEPTH);
    localparam int MAXC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    // The counter holds "cycles left after this one", so a state lasts LOAD+1 cycles.
    localparam logic [CW-1:0] ON_LOAD  = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0] OFF_LOAD = CW'(OFF_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [LW-1:0]   len_q, len_d;
    logic            ovf_q, ovf_d;
    logic            done_q, done_d;
    logic            strobe_q, strobe_d;
    logic [1:0]      color_q, color_d;
    logic            on_q, on_d;
    logic            wr_en;
    logic [1:0]      mem [DEPTH];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        len_d    = len_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        strobe_d = 1'b0;
        color_d  = color_q;
        on_d     = on_q;
        wr_en    = 1'b0;

        if (clear) begin
            state_d = S_IDLE;
            len_d   = '0;
            ovf_d   = 1'b0;
            // Aborting mid-flash must still turn the light/tone off.
            if (state_q == S_ON) begin
                strobe_d = 1'b1;
                on_d     = 1'b0;
            end
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (push) begin
                        if (len_q == LW'(DEPTH)) begin
                            ovf_d = 1'b1;
                        end else begin
                            wr_en = 1'b1;
                            len_d = len_q + LW'(1);
                        end
                    end
                    if (start) begin
                        if (len_q != '0) begin
                            state_d  = S_ON;
                            idx_d    = '0;
                            cnt_d    = ON_LOAD;
                            strobe_d = 1'b1;
                            on_d     = 1'b1;
                            color_d  = mem[0];
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                S_ON: begin
                    if (cnt_q == '0) begin
                        state_d  = S_OFF;
                        cnt_d    = OFF_LOAD;
                        strobe_d = 1'b1;
                        on_d     = 1'b0;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                S_OFF: begin
                    if (cnt_q == '0) begin
                        if (LW'(idx_q) + LW'(1) == len_q) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d  = S_ON;
                            idx_d    = idx_q + IW'(1);
                            cnt_d    = ON_LOAD;
                            strobe_d = 1'b1;
                            on_d     = 1'b1;
                            color_d  = mem[idx_q + IW'(1)];
                        end
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            len_q    <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
            strobe_q <= 1'b0;
            color_q  <= 2'b00;
            on_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            len_q    <= len_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
            strobe_q <= strobe_d;
            color_q  <= color_d;
            on_q     <= on_d;
        end
    end

    // Buffer storage needs no reset: len gates every read.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[len_q[IW-1:0]] <= push_color;
        end
    end

    assign len        = len_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;
    assign overflow   = ovf_q;
    assign led_strobe = strobe_q;
    assign led_color  = color_q;
    assign led_on     = on_q;

`ifdef SEQ_PLAYER_AUDIO_EN
    assign snd_strobe = strobe_q;
    assign snd_color  = {1'b0, color_q};
    assign snd_on     = on_q;
`else
    assign snd_strobe = 1'b0;
    assign snd_color  = 3'b000;
    assign snd_on     = 1'b0;
`endif

endmodule

// File: tb/tb_seq_player.sv
module tb_seq_player;

    localparam int DEPTH = 4;
    localparam int ONC   = 4;
    localparam int OFFC  = 2;
    localparam int P     = ONC + OFFC;

    logic       clock = 1'b0;
    logic       reset;
    logic       push;
    logic [1:0] push_color;
    logic       clear;
    logic       start;
    logic [2:0] len;
    logic       busy, done, overflow;
    logic       led_strobe, led_on, snd_strobe, snd_on;
    logic [1:0] led_color;
    logic [2:0] snd_color;

    seq_player #(.DEPTH(DEPTH), .ON_CYCLES(ONC), .OFF_CYCLES(OFFC)) dut (
        .clock(clock), .reset(reset), .push(push), .push_color(push_color),
        .clear(clear), .start(start), .len(len), .busy(busy), .done(done),
        .overflow(overflow), .led_strobe(led_strobe), .led_color(led_color),
        .led_on(led_on), .snd_strobe(snd_strobe), .snd_color(snd_color),
        .snd_on(snd_on)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Reference model: the buffer as a queue, playback position as elapsed cycles since start.
    int         mq[$];
    bit         m_ovf, m_play, m_on, m_strobe, m_done;
    int         m_t, m_n;
    logic [1:0] m_col;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf = 0; m_play = 0; m_on = 0; m_strobe = 0; m_done = 0;
        m_t = 0; m_n = 0; m_col = 2'b00;
    endtask

    task automatic model_edge(input bit p, input logic [1:0] pc, input bit c, input bit s);
        int sz;
        m_strobe = 0;
        m_done   = 0;
        if (c) begin
            if (m_play && ((m_t - 1) % P) < ONC) begin
                m_strobe = 1;
                m_on     = 0;
            end
            m_play = 0;
            mq.delete();
            m_ovf = 0;
        end else if (m_play) begin
            m_t++;
            if (m_t == m_n * P + 1) begin
                m_play = 0;
                m_done = 1;
            end else if (((m_t - 1) % P) == 0) begin
                m_strobe = 1;
                m_on     = 1;
                m_col    = 2'(mq[(m_t - 1) / P]);
            end else if (((m_t - 1) % P) == ONC) begin
                m_strobe = 1;
                m_on     = 0;
            end
        end else begin
            sz = mq.size();
            if (p) begin
                if (sz == DEPTH) m_ovf = 1;
                else mq.push_back(int'(pc));
            end
            if (s) begin
                if (sz > 0) begin
                    m_play = 1; m_t = 1; m_n = sz;
                    m_strobe = 1; m_on = 1; m_col = 2'(mq[0]);
                end else begin
                    m_done = 1;
                end
            end
        end
    endtask

    function automatic logic [15:0] exp_vec();
        logic [4:0] snd;
`ifdef SEQ_PLAYER_AUDIO_EN
        snd = {m_strobe, 1'b0, m_col, m_on};
`else
        snd = 5'b0;
`endif
        return {3'(mq.size()), m_play, m_done, m_ovf, m_strobe, m_col, m_on, snd};
    endfunction

    function automatic logic [15:0] act_vec();
        return {len, busy, done, overflow, led_strobe, led_color, led_on,
                snd_strobe, snd_color, snd_on};
    endfunction

    // One clock: drive inputs, advance the model, compare every output against it.
    task automatic step(input bit p, input logic [1:0] pc, input bit c, input bit s);
        push = p; push_color = pc; clear = c; start = s;
        @(posedge clock);
        #1;
        cyc++;
        model_edge(p, pc, c, s);
        chk("model", 32'(act_vec()), 32'(exp_vec()));
        push = 0; clear = 0; start = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 2'b00, 0, 0);
    endtask

    typedef struct {
        bit         p;
        logic [1:0] col;
        bit         c;
        bit         s;
        int         idle_n;
        int         exp_len;
        bit         exp_ovf;
    } vec_t;

    vec_t tbl[8];
    int   k, rel;
    bit   exp_b, exp_s;
    int   seen_done;

    initial begin
        reset = 1; push = 0; push_color = 0; clear = 0; start = 0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        chk("reset_outputs", 32'(act_vec()), 32'h0);
        reset = 0;

        // Scenario 1: push 01, 11; start; absolute timing against hand-derived cycles.
        step(1, 2'b01, 0, 0);
        chk("len_after_push1", 32'(len), 32'd1);
        step(1, 2'b11, 0, 0);
        chk("len_after_push2", 32'(len), 32'd2);
        step(0, 2'b00, 0, 1);
        k = cyc;
        for (int r = 1; r <= 14; r++) begin
            if (r > 1) step(0, 2'b00, 0, 0);
            rel   = cyc - k + 1;
            exp_s = (rel == 1 || rel == 5 || rel == 7 || rel == 11);
            exp_b = (rel >= 1 && rel <= 12);
            chk("s1_strobe", 32'(led_strobe), 32'(exp_s));
            chk("s1_busy", 32'(busy), 32'(exp_b));
            chk("s1_done", 32'(done), 32'(rel == 13));
            if (exp_s) chk("s1_color_on", 32'({led_color, led_on}),
                           32'({(rel < 7) ? 2'b01 : 2'b11, (rel == 1 || rel == 7)}));
        end

        // Scenario 2: start with an empty buffer.
        step(0, 2'b00, 1, 0);
        step(0, 2'b00, 0, 1);
        chk("empty_start_done", 32'({done, busy, led_strobe}), 32'b100);
        idle(3);

        // Scenario 3: table of pushes/start/clear with expected len and overflow after each record.
        tbl[0] = '{1, 2'b00, 0, 0, 0, 1, 0};
        tbl[1] = '{1, 2'b01, 0, 0, 0, 2, 0};
        tbl[2] = '{1, 2'b10, 0, 0, 0, 3, 0};
        tbl[3] = '{1, 2'b11, 0, 0, 0, 4, 0};
        tbl[4] = '{1, 2'b01, 0, 0, 0, 4, 1};
        tbl[5] = '{0, 2'b00, 0, 1, 4 * P + 1, 4, 1};
        tbl[6] = '{1, 2'b10, 1, 1, 2, 0, 0};
        tbl[7] = '{1, 2'b10, 0, 0, 0, 1, 0};
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].p, tbl[i].col, tbl[i].c, tbl[i].s);
            idle(tbl[i].idle_n);
            chk("tbl_len", 32'(len), 32'(tbl[i].exp_len));
            chk("tbl_ovf", 32'(overflow), 32'(tbl[i].exp_ovf));
        end

        // Scenario 4: clear during the first ON step.
        step(1, 2'b10, 0, 0);
        step(0, 2'b00, 0, 1);
        k = cyc;
        idle(2);
        step(0, 2'b00, 1, 0);
        chk("clr_off_strobe", 32'({led_strobe, led_on, led_color, busy, len}),
            32'({1'b1, 1'b0, 2'b10, 1'b0, 3'd0}));
        seen_done = 0;
        for (int i = 0; i < 20; i++) begin
            step(0, 2'b00, 0, 0);
            seen_done += int'(done);
        end
        chk("clr_no_done", 32'(seen_done), 32'd0);

        // Scenario 5: push/start while busy are ignored; restart in the done cycle.
        step(1, 2'b11, 0, 0);
        step(1, 2'b00, 0, 0);
        step(0, 2'b00, 0, 1);
        k = cyc;
        idle(1);
        step(1, 2'b01, 0, 1);
        chk("busy_push_len", 32'(len), 32'd2);
        seen_done = 0;
        for (int i = 0; i < 40 && seen_done == 0; i++) begin
            step(0, 2'b00, 0, 0);
            if (done) seen_done = cyc - k + 1;
        end
        chk("busy_done_cycle", 32'(seen_done), 32'(1 + 2 * P));
        step(0, 2'b00, 0, 1);
        chk("restart_first", 32'({led_strobe, led_on, led_color, busy}), 32'({1'b1, 1'b1, 2'b11, 1'b1}));
        idle(2 * P + 2);

        // Random traffic against the model; push and start never share a cycle.
        for (int i = 0; i < 3000; i++) begin
            bit rp, rc, rs;
            rp = ($urandom_range(0, 99) < 30);
            rc = ($urandom_range(0, 99) < 2);
            rs = !rp && ($urandom_range(0, 99) < 8);
            step(rp, 2'($urandom_range(0, 3)), rc, rs);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
